// File: rtl/sra_seq_shifter.sv
// Multi-cycle right shifter: ASR, LSR, ROR and round-half-up ASR, STEP bits per clock,
// with a start/done handshake and a sticky flag of the bits shifted out.
module sra_seq_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 2,
    localparam int unsigned SW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [SW-1:0]    shamt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             sticky
);

    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_RND = 2'b11;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    eff_q;
    logic [SW-1:0]    rem;
    logic             full_q;
    logic             acc_q;

    logic [SW-1:0]    eff_c;
    logic [SW-1:0]    k_c;
    logic [WIDTH-1:0] shifted_c;
    logic [WIDTH-1:0] out_bits_c;
    logic [WIDTH-1:0] rounded_c;
    logic             last_c;
    logic             guard_c;
    logic             sticky_c;
    logic             arith_c;

    // Effective amount from the raw request: rotate wraps, the others saturate at WIDTH.
    always_comb begin
        eff_c = '0;
        if (mode == MODE_ROR) begin
            eff_c = shamt % SW'(WIDTH);
        end else begin
            eff_c = (shamt > SW'(WIDTH)) ? SW'(WIDTH) : shamt;
        end
    end

    // One SHIFT-cycle datapath: shifted value, outgoing bits, guard and rounded result.
    always_comb begin
        k_c        = (rem < SW'(STEP)) ? rem : SW'(STEP);
        last_c     = (rem == k_c);
        arith_c    = (mode_q != MODE_LSR) && (mode_q != MODE_ROR);
        shifted_c  = '0;
        case (mode_q)
            MODE_LSR: shifted_c = shreg >> k_c;
            MODE_ROR: shifted_c = (shreg >> k_c) | (shreg << (SW'(WIDTH) - k_c));
            default:  shifted_c = WIDTH'($signed(shreg) >>> k_c);
        endcase
        out_bits_c = shreg & ~(ONES << k_c);
        // A full-width arithmetic shift pushes out the sign itself; that bit is kept as sign, not sticky.
        if (arith_c && full_q && last_c) begin
            out_bits_c = out_bits_c & ~(ONE << (k_c - SW'(1)));
        end
        guard_c   = |(shreg & (ONE << (k_c - SW'(1))));
        sticky_c  = (mode_q == MODE_ROR) ? 1'b0 : (acc_q | (|out_bits_c));
        rounded_c = shifted_c + (((mode_q == MODE_RND) && guard_c) ? ONE : '0);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode_q <= '0;
            shreg  <= '0;
            eff_q  <= '0;
            rem    <= '0;
            full_q <= 1'b0;
            acc_q  <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg  <= operand;
                        mode_q <= mode;
                        eff_q  <= eff_c;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem    <= eff_q;
                    acc_q  <= 1'b0;
                    full_q <= (eff_q == SW'(WIDTH));
                    if (eff_q == '0) begin
                        result <= shreg;
                        sticky <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg <= shifted_c;
                    rem   <= rem - k_c;
                    acc_q <= sticky_c;
                    if (last_c) begin
                        result <= rounded_c;
                        sticky <= sticky_c;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
